// File: rtl/alu_rr_arbiter.sv
// Round-robin arbiter sharing one pipelined ALU among NREQ requesters.
// Results are steered back to their issuer through a tag shift pipeline.
module alu_rr_arbiter #(
  parameter int NREQ    = 4,
  parameter int DW      = 8,
  parameter int OPW     = 4,
  parameter int ALU_LAT = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ*OPW-1:0] req_op,
  input  logic [NREQ*DW-1:0]  req_a,
  input  logic [NREQ*DW-1:0]  req_b,
  output logic [NREQ-1:0]   req_ready,
  input  logic              pause,
  output logic [OPW-1:0]    alu_instruction,
  output logic [DW-1:0]     alu_a,
  output logic [DW-1:0]     alu_b,
  input  logic [DW-1:0]     alu_result,
  output logic [NREQ-1:0]   rsp_valid,
  output logic [DW-1:0]     rsp_data,
  output logic              busy
);

  localparam int IDW = $clog2(NREQ);

  logic [IDW-1:0]     rr_ptr;
  logic               grant_any;
  logic [IDW-1:0]     grant_id;
  logic [IDW:0]       scan_idx;
  logic [ALU_LAT-1:0] tag_vld;
  logic [IDW-1:0]     tag_id [ALU_LAT];

  // Scan upward from rr_ptr; rr_ptr + k never exceeds 2*NREQ-2.
  always_comb begin
    grant_any = 1'b0;
    grant_id  = '0;
    scan_idx  = '0;
    for (int k = 0; k < NREQ; k++) begin
      scan_idx = {1'b0, rr_ptr} + (IDW+1)'(k);
      if (scan_idx >= (IDW+1)'(NREQ))
        scan_idx = scan_idx - (IDW+1)'(NREQ);
      if (!pause && !grant_any &&
          req_valid[scan_idx[IDW-1:0]]) begin
        grant_any = 1'b1;
        grant_id  = scan_idx[IDW-1:0];
      end
    end
  end

  always_comb begin
    req_ready       = '0;
    alu_instruction = '0;
    alu_a           = '0;
    alu_b           = '0;
    if (grant_any) begin
      req_ready[grant_id] = 1'b1;
      alu_instruction = req_op[grant_id*OPW +: OPW];
      alu_a           = req_a[grant_id*DW +: DW];
      alu_b           = req_b[grant_id*DW +: DW];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rr_ptr <= '0;
    end else if (grant_any) begin
      if (grant_id == IDW'(NREQ-1))
        rr_ptr <= '0;
      else
        rr_ptr <= grant_id + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tag_vld <= '0;
      for (int s = 0; s < ALU_LAT; s++)
        tag_id[s] <= '0;
    end else begin
      tag_vld[0] <= grant_any;
      tag_id[0]  <= grant_id;
      for (int s = 1; s < ALU_LAT; s++) begin
        tag_vld[s] <= tag_vld[s-1];
        tag_id[s]  <= tag_id[s-1];
      end
    end
  end

  always_comb begin
    rsp_valid = '0;
    if (tag_vld[ALU_LAT-1])
      rsp_valid[tag_id[ALU_LAT-1]] = 1'b1;
  end

  assign rsp_data = alu_result;
  assign busy     = |tag_vld;

endmodule

// File: tb/tb_alu_rr_arbiter.sv
// Bench for alu_rr_arbiter with a two-stage registered ALU stand-in.
// A negedge scoreboard tracks grants, responses and busy every cycle.
module tb_alu_rr_arbiter;

  localparam int NREQ = 4;
  localparam int DW   = 8;
  localparam int OPW  = 4;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [NREQ-1:0]   req_valid = '0;
  logic [NREQ*OPW-1:0] req_op = '0;
  logic [NREQ*DW-1:0]  req_a = '0;
  logic [NREQ*DW-1:0]  req_b = '0;
  logic [NREQ-1:0]   req_ready;
  logic              pause = 1'b0;
  logic [OPW-1:0]    alu_instruction;
  logic [DW-1:0]     alu_a;
  logic [DW-1:0]     alu_b;
  logic [DW-1:0]     alu_result;
  logic [NREQ-1:0]   rsp_valid;
  logic [DW-1:0]     rsp_data;
  logic              busy;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  alu_rr_arbiter #(.NREQ(NREQ), .DW(DW), .OPW(OPW), .ALU_LAT(2)) dut (
    .clk(clk), .reset(rst_n),
    .req_valid(req_valid), .req_op(req_op),
    .req_a(req_a), .req_b(req_b),
    .req_ready(req_ready), .pause(pause),
    .alu_instruction(alu_instruction),
    .alu_a(alu_a), .alu_b(alu_b),
    .alu_result(alu_result),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .busy(busy)
  );

  // ALU stand-in: inputs registered, then result registered
  logic [OPW-1:0] alu_ins_q;
  logic [DW-1:0]  alu_a_q, alu_b_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_ins_q  <= '0;
      alu_a_q    <= '0;
      alu_b_q    <= '0;
      alu_result <= '0;
    end else begin
      alu_ins_q  <= alu_instruction;
      alu_a_q    <= alu_a;
      alu_b_q    <= alu_b;
      alu_result <= (alu_ins_q == 4'd1) ? alu_a_q - alu_b_q
                                        : alu_a_q + alu_b_q;
    end
  end

  function automatic logic [DW-1:0] alu_fn(
    input logic [OPW-1:0] op,
    input logic [DW-1:0] a, input logic [DW-1:0] b);
    return (op == 4'd1) ? a - b : a + b;
  endfunction

  typedef struct {
    int          due;
    int          id;
    logic [DW-1:0] data;
  } exp_t;

  exp_t q[$];
  int   mcyc = 0;
  int   mptr = 0;

  // Scoreboard: own round-robin model, expected results queued on grant
  always @(negedge clk) begin
    exp_t e;
    logic [NREQ-1:0] exp_rdy;
    int g;
    int idx;
    if (!rst_n) begin
      q.delete();
      mptr = 0;
      n_cmp++;
      if (req_ready !== '0 || rsp_valid !== '0 || busy !== 1'b0) begin
        n_err++;
        $display("FAIL sb_reset: rdy=%b rsp=%b busy=%b want 0/0/0",
                 req_ready, rsp_valid, busy);
      end
    end else begin
      n_cmp++;
      if (busy !== (q.size() != 0)) begin
        n_err++;
        $display("FAIL sb_busy cyc%0d: got %b want %b",
                 mcyc, busy, q.size() != 0);
      end
      if (q.size() > 0 && q[0].due == mcyc) begin
        e = q.pop_front();
        n_cmp++;
        if (rsp_valid !== NREQ'(1 << e.id) || rsp_data !== e.data) begin
          n_err++;
          $display("FAIL sb_rsp cyc%0d: got %b/%h want %b/%h", mcyc,
                   rsp_valid, rsp_data, NREQ'(1 << e.id), e.data);
        end
      end else begin
        n_cmp++;
        if (rsp_valid !== '0) begin
          n_err++;
          $display("FAIL sb_norsp cyc%0d: got %b want 0",
                   mcyc, rsp_valid);
        end
      end
      g = -1;
      for (int k = 0; k < NREQ; k++) begin
        idx = (mptr + k) % NREQ;
        if (!pause && g < 0 && req_valid[idx]) g = idx;
      end
      exp_rdy = (g < 0) ? '0 : NREQ'(1 << g);
      n_cmp++;
      if (req_ready !== exp_rdy) begin
        n_err++;
        $display("FAIL sb_grant cyc%0d: got %b want %b",
                 mcyc, req_ready, exp_rdy);
      end
      if (g >= 0) begin
        e.due  = mcyc + 2;
        e.id   = g;
        e.data = alu_fn(req_op[g*OPW +: OPW],
                        req_a[g*DW +: DW], req_b[g*DW +: DW]);
        q.push_back(e);
        mptr = (g + 1) % NREQ;
      end
    end
    mcyc++;
  end

  task automatic drive_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [3:0] op,
                         input logic [7:0] a, input logic [7:0] b);
    req_op[i*OPW +: OPW] = op;
    req_a[i*DW +: DW]    = a;
    req_b[i*DW +: DW]    = b;
  endtask

  task automatic do_reset();
    drive_edge();
    req_valid = '0;
    pause     = 1'b0;
    rst_n     = 1'b0;
    drive_edge();
    drive_edge();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    n_cmp++;
    if (req_ready !== '0 || rsp_valid !== '0 || busy !== 1'b0 ||
        alu_instruction !== '0 || alu_a !== '0) begin
      n_err++;
      $display("FAIL reset_outs: rdy=%b rsp=%b busy=%b ins=%h a=%h",
               req_ready, rsp_valid, busy, alu_instruction, alu_a);
    end
    drive_edge();
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_single();
    drive_edge();
    set_req(0, 4'd0, 8'h12, 8'h34);
    req_valid = 4'b0001;
    @(negedge clk);
    n_cmp++;
    if (req_ready !== 4'b0001 || alu_a !== 8'h12 || alu_b !== 8'h34) begin
      n_err++;
      $display("FAIL single_grant: rdy=%b a=%h b=%h want 0001/12/34",
               req_ready, alu_a, alu_b);
    end
    drive_edge();
    req_valid = '0;
    @(negedge clk);
    n_cmp++;
    if (busy !== 1'b1 || rsp_valid !== '0) begin
      n_err++;
      $display("FAIL single_n1: busy=%b rsp=%b want 1/0000",
               busy, rsp_valid);
    end
    @(negedge clk);
    n_cmp++;
    if (rsp_valid !== 4'b0001 || rsp_data !== 8'h46 || busy !== 1'b1) begin
      n_err++;
      $display("FAIL single_rsp: rsp=%b data=%h busy=%b want 0001/46/1",
               rsp_valid, rsp_data, busy);
    end
    @(negedge clk);
    n_cmp++;
    if (busy !== 1'b0) begin
      n_err++;
      $display("FAIL single_idle: busy=%b want 0", busy);
    end
  endtask

  task automatic test_fairness();
    do_reset();
    for (int r = 0; r < NREQ; r++)
      set_req(r, 4'd0, 8'(r * 16), 8'(r + 1));
    req_valid = '1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      n_cmp++;
      if (req_ready !== NREQ'(1 << (k % NREQ))) begin
        n_err++;
        $display("FAIL fair_order k%0d: got %b want %b",
                 k, req_ready, NREQ'(1 << (k % NREQ)));
      end
      drive_edge();
      for (int r = 0; r < NREQ; r++)
        set_req(r, 4'd0, 8'(r * 16 + k + 1), 8'(r + 1));
    end
    req_valid = '0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_wrap_sub();
    drive_edge();
    set_req(2, 4'd1, 8'h05, 8'h07);
    req_valid = 4'b0100;
    @(negedge clk);
    drive_edge();
    req_valid = '0;
    @(negedge clk);
    @(negedge clk);
    n_cmp++;
    if (rsp_valid !== 4'b0100 || rsp_data !== 8'hFE) begin
      n_err++;
      $display("FAIL wrap_sub: rsp=%b data=%h want 0100/fe",
               rsp_valid, rsp_data);
    end
  endtask

  task automatic test_pause();
    logic [NREQ-1:0] exp_rsp [5];
    logic            exp_busy [5];
    exp_rsp  = '{4'b0001, 4'b0010, 4'b0000, 4'b0000, 4'b0000};
    exp_busy = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    do_reset();
    for (int r = 0; r < NREQ; r++)
      set_req(r, 4'd0, 8'(r + 8'h40), 8'h01);
    req_valid = '1;
    @(negedge clk);
    drive_edge();
    @(negedge clk);
    drive_edge();
    pause = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      n_cmp++;
      if (req_ready !== '0 || rsp_valid !== exp_rsp[k] ||
          busy !== exp_busy[k]) begin
        n_err++;
        $display("FAIL pause k%0d: rdy=%b rsp=%b busy=%b want 0/%b/%b",
                 k, req_ready, rsp_valid, busy, exp_rsp[k], exp_busy[k]);
      end
      drive_edge();
    end
    pause = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (req_ready !== 4'b0100) begin
      n_err++;
      $display("FAIL pause_resume: got %b want 0100", req_ready);
    end
    drive_edge();
    req_valid = '0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_back_to_back();
    logic [7:0] base;
    base = 8'hFC;
    drive_edge();
    for (int i = 0; i < 8; i++) begin
      if (i < 6) begin
        set_req(3, 4'd0, base + 8'(i), 8'h01);
        req_valid = 4'b1000;
      end else begin
        req_valid = '0;
      end
      @(negedge clk);
      if (i < 6) begin
        n_cmp++;
        if (req_ready !== 4'b1000) begin
          n_err++;
          $display("FAIL stream_grant i%0d: got %b want 1000",
                   i, req_ready);
        end
      end
      if (i >= 2) begin
        n_cmp++;
        if (rsp_valid !== 4'b1000 ||
            rsp_data !== base + 8'(i - 2) + 8'h01) begin
          n_err++;
          $display("FAIL stream_rsp i%0d: rsp=%b data=%h want 1000/%h",
                   i, rsp_valid, rsp_data, base + 8'(i - 2) + 8'h01);
        end
      end
      drive_edge();
    end
    req_valid = '0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset_midflight();
    do_reset();
    repeat (2) drive_edge();
    set_req(1, 4'd0, 8'h20, 8'h03);
    req_valid = 4'b0010;
    @(negedge clk);
    drive_edge();
    req_valid = '0;
    rst_n     = 1'b0;
    @(negedge clk);
    drive_edge();
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (rsp_valid !== '0 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL midflight_lost: rsp=%b busy=%b want 0000/0",
               rsp_valid, busy);
    end
    drive_edge();
    set_req(1, 4'd0, 8'h11, 8'h22);
    set_req(2, 4'd1, 8'h50, 8'h10);
    req_valid = 4'b0110;
    @(negedge clk);
    n_cmp++;
    if (req_ready !== 4'b0010) begin
      n_err++;
      $display("FAIL midflight_ptr: got %b want 0010", req_ready);
    end
    drive_edge();
    req_valid = '0;
    @(negedge clk);
    @(negedge clk);
    n_cmp++;
    if (rsp_valid !== 4'b0010 || rsp_data !== 8'h33) begin
      n_err++;
      $display("FAIL midflight_next: rsp=%b data=%h want 0010/33",
               rsp_valid, rsp_data);
    end
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: timeout reached, want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_fairness();
    test_wrap_sub();
    test_pause();
    test_back_to_back();
    test_reset_midflight();
    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
